// File: rtl/sync_debounce_edge.sv
// Debounce and edge detect for an already-synchronized level: a new level is accepted only
// after STABLE_CYCLES consecutive equal samples, then a one-cycle rise or fall pulse is emitted.
module sync_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int EVT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    LOW_STABLE,
    CHK_HIGH,
    HIGH_STABLE,
    CHK_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;
  logic [EVT_W-1:0] evt_nxt;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned
  // (an unassigned path would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      LOW_STABLE: begin
        if (en && din) begin
          if (SINGLE) begin
            state_nxt = HIGH_STABLE;
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CHK_HIGH;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      CHK_HIGH: begin
        // Disable or a glitch abandons the check without touching level.
        if (!en || !din) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH_STABLE;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH_STABLE: begin
        if (en && !din) begin
          if (SINGLE) begin
            state_nxt = LOW_STABLE;
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CHK_LOW;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      CHK_LOW: begin
        if (!en || din) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW_STABLE;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOW_STABLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
    // A clear coinciding with a rise keeps that rise counted.
    evt_nxt  = clr_cnt ? EVT_W'(rise_nxt) : evt_cnt + EVT_W'(rise_nxt);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOW_STABLE;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
      evt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level   <= level_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      busy    <= busy_nxt;
      evt_cnt <= evt_nxt;
    end
  end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Self-checking bench: three debouncer instances (SC=4/EVT_W=16, SC=4/EVT_W=2, SC=1/EVT_W=4)
// share stimulus; each is compared every cycle against a run-length reference model.
module tb_sync_debounce_edge;

  logic clk = 1'b0;
  logic rst = 1'b1, din = 1'b0, en = 1'b0, clr_cnt = 1'b0;

  logic        lv [3];
  logic        rs [3];
  logic        fl [3];
  logic        bz [3];
  logic [15:0] evt0;
  logic [1:0]  evt1;
  logic [3:0]  evt2;
  logic [31:0] ev [3];

  assign ev[0] = 32'(evt0);
  assign ev[1] = 32'(evt1);
  assign ev[2] = 32'(evt2);

  always #5 clk = ~clk;

  sync_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8), .EVT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr_cnt(clr_cnt),
    .level(lv[0]), .rise(rs[0]), .fall(fl[0]), .busy(bz[0]), .evt_cnt(evt0));
  sync_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8), .EVT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr_cnt(clr_cnt),
    .level(lv[1]), .rise(rs[1]), .fall(fl[1]), .busy(bz[1]), .evt_cnt(evt1));
  sync_debounce_edge #(.STABLE_CYCLES(1), .CNT_W(4), .EVT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr_cnt(clr_cnt),
    .level(lv[2]), .rise(rs[2]), .fall(fl[2]), .busy(bz[2]), .evt_cnt(evt2));

  // Reference model: count consecutive enabled samples that disagree with the level.
  int sc_m [3] = '{4, 4, 1};
  int ew_m [3] = '{16, 2, 4};
  int lvl_m [3], run_m [3], evt_m [3], rise_m [3], fall_m [3];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic e, input logic c);
    rst = r; din = d; en = e; clr_cnt = c;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rise_m[i] = 0;
      fall_m[i] = 0;
      if (r) begin
        lvl_m[i] = 0; run_m[i] = 0; evt_m[i] = 0;
      end else begin
        if (e && (int'(d) != lvl_m[i])) begin
          run_m[i]++;
          if (run_m[i] == sc_m[i]) begin
            lvl_m[i] = int'(d);
            rise_m[i] = int'(d);
            fall_m[i] = int'(!d);
            run_m[i] = 0;
          end
        end else begin
          run_m[i] = 0;
        end
        if (c) evt_m[i] = rise_m[i];
        else   evt_m[i] = (evt_m[i] + rise_m[i]) % (1 << ew_m[i]);
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_level", i), 32'(lv[i]), 32'(lvl_m[i]));
      check($sformatf("d%0d_rise", i), 32'(rs[i]), 32'(rise_m[i]));
      check($sformatf("d%0d_fall", i), 32'(fl[i]), 32'(fall_m[i]));
      check($sformatf("d%0d_busy", i), 32'(bz[i]), 32'(run_m[i] != 0));
      check($sformatf("d%0d_evt", i), ev[i], 32'(evt_m[i]));
    end
  endtask

  task automatic hold(input logic d, input int n);
    for (int k = 0; k < n; k++) step(1'b0, d, 1'b1, 1'b0);
  endtask

  int exp_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    // 1. reset, then din=1 held: accept after the 4th sampling edge
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_reset_level", 32'(lv[0]), 32'd0);
    check("t1_reset_evt", ev[0], 32'd0);
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 1);
      check("t1_busy", 32'(bz[0]), 32'd1);
      check("t1_level_pending", 32'(lv[0]), 32'd0);
    end
    hold(1'b1, 1);
    check("t1_level", 32'(lv[0]), 32'd1);
    check("t1_rise", 32'(rs[0]), 32'd1);
    check("t1_evt", ev[0], 32'd1);
    check("t1_sc1_level", 32'(lv[2]), 32'd1);
    hold(1'b1, 1);
    check("t1_rise_one_cycle", 32'(rs[0]), 32'd0);

    // 3. glitch of one low sample gives no fall; 4 low samples do
    hold(1'b0, 1);
    hold(1'b1, 2);
    check("t3_glitch_level", 32'(lv[0]), 32'd1);
    hold(1'b0, 4);
    check("t3_level", 32'(lv[0]), 32'd0);
    check("t3_fall", 32'(fl[0]), 32'd1);
    check("t3_evt", ev[0], 32'd1);
    hold(1'b0, 1);
    check("t3_fall_one_cycle", 32'(fl[0]), 32'd0);

    // 2. three high samples then low: nothing accepted
    hold(1'b1, 3);
    hold(1'b0, 1);
    check("t2_level", 32'(lv[0]), 32'd0);
    check("t2_busy", 32'(bz[0]), 32'd0);
    check("t2_evt", ev[0], 32'd1);

    // 4. EVT_W=2 wrap over five rises
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 4);
      check("t4_evt_wrap", ev[1], 32'(exp_seq[k]));
      hold(1'b0, 4);
    end

    // 5. clear on the accepting edge keeps the event; clear alone zeroes
    check("t5_evt_before", ev[0], 32'd5);
    hold(1'b1, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t5_clr_with_rise", ev[0], 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t5_clr_alone", ev[0], 32'd0);

    // 6. reset while level=1, then full requalification
    hold(1'b1, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_rst_level", 32'(lv[0]), 32'd0);
    check("t6_rst_evt", ev[0], 32'd0);
    hold(1'b1, 3);
    check("t6_requal_pending", 32'(lv[0]), 32'd0);
    hold(1'b1, 1);
    check("t6_requal_level", 32'(lv[0]), 32'd1);
    // en=0 during CHK_HIGH aborts the check
    hold(1'b0, 4);
    hold(1'b1, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_abort_busy", 32'(bz[0]), 32'd0);
    check("t6_abort_level", 32'(lv[0]), 32'd0);
    hold(1'b1, 3);
    check("t6_abort_no_rise", 32'(lv[0]), 32'd0);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      logic d, e, c, r;
      d = ($urandom_range(0, 3) == 0) ? ~din : din;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(r, d, e, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
